axi_dma_w_burst: RTL and testbench



---
 rtl/axi_dma_w_burst_pkg.sv | 26 ++
 rtl/axi_dma_burst_len.sv | 41 ++++
 rtl/axi_dma_w_burst.sv | 174 +++++++++++++++++
 tb/tb_axi_dma_w_burst.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_w_burst_pkg.sv
// Shared AXI field widths, fixed AW field values, FSM encodings and the 4 KB boundary constant
// for the write-DMA burst master (4 KB splitting is enabled by AXI_DMA_W_4K_SPLIT_EN).
package axi_dma_w_burst_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_VAL  = 4'd2;
    localparam logic [AXI_PROT_W-1:0]  AXI_PROT_VAL   = 3'b010;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] W_BURST_IDLE = 2'd0;
    localparam logic [1:0] W_BURST_ADDR = 2'd1;
    localparam logic [1:0] W_BURST_DATA = 2'd2;
    localparam logic [1:0] W_BURST_RESP = 2'd3;

    localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_dma_burst_len.sv
// Combinational burst length: min(remaining, MAX_LEN[, beats to the next 4 KB boundary]).
// The boundary term is present only when AXI_DMA_W_4K_SPLIT_EN is defined.
module axi_dma_burst_len
    import axi_dma_w_burst_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int MAX_LEN    = 16,
    parameter int LOG2_BYTES = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]  remaining,
    output logic [8:0]        len
);

    logic [31:0] rem_ext;
    logic [31:0] cap;

`ifdef AXI_DMA_W_4K_SPLIT_EN
    logic [12:0] to_bnd;
    logic [31:0] bnd_beats;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[ADDR_W-1:12];

    always_comb begin
        to_bnd    = 13'(BOUNDARY_4K) - {1'b0, addr[11:0]};
        bnd_beats = 32'(to_bnd >> LOG2_BYTES);
        cap       = (32'(MAX_LEN) < bnd_beats) ? 32'(MAX_LEN) : bnd_beats;
    end
`else
    logic unused_addr;

    assign unused_addr = ^addr;
    assign cap         = 32'(MAX_LEN);
`endif

    assign rem_ext = 32'(remaining);
    assign len     = 9'((rem_ext < cap) ? rem_ext : cap);

endmodule

// File: rtl/axi_dma_w_burst.sv
// AXI4 write-DMA master: splits a num_beats stream run into INCR bursts, one outstanding at a time.
// Define AXI_DMA_W_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module axi_dma_w_burst
    import axi_dma_w_burst_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [CNT_W-1:0]       num_beats,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    input  logic                   valid,
    output logic                   ready,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wstrb,
    output logic [AXI_ID_W-1:0]    m_axi_awid,
    output logic [ADDR_W-1:0]      m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]   m_axi_awlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
    output logic [AXI_BURST_W-1:0] m_axi_awburst,
    output logic                   m_axi_awlock,
    output logic [AXI_CACHE_W-1:0] m_axi_awcache,
    output logic [AXI_PROT_W-1:0]  m_axi_awprot,
    output logic [AXI_QOS_W-1:0]   m_axi_awqos,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [DATA_W-1:0]      m_axi_wdata,
    output logic [DATA_W/8-1:0]    m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [AXI_ID_W-1:0]    m_axi_bid,
    input  logic [AXI_RESP_W-1:0]  m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [1:0]             state_dbg
);

    localparam int BYTES      = DATA_W / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    // Stream/W handshake: a beat moves on a cycle where valid and m_axi_wready are both high
    // in DATA; the stream sees ready = m_axi_wready, the W channel sees wvalid = valid.
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  nxt_rem;
    logic [8:0]        len_r;
    logic [8:0]        nxt_len;
    logic [8:0]        beat_cnt;
    logic              in_data;
    logic              unused_bid;

    // One length calculator serves both the initial burst and every follow-on burst.
    always_comb begin
        if (state == W_BURST_RESP) begin
            nxt_addr = addr + (ADDR_W'(len_r) << LOG2_BYTES);
            nxt_rem  = remaining - CNT_W'(len_r);
        end else begin
            nxt_addr = start_addr & ALIGN_MASK;
            nxt_rem  = num_beats;
        end
    end

    axi_dma_burst_len #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .MAX_LEN    (MAX_LEN),
        .LOG2_BYTES (LOG2_BYTES)
    ) u_burst_len (
        .addr      (nxt_addr),
        .remaining (nxt_rem),
        .len       (nxt_len)
    );

    assign in_data       = (state == W_BURST_DATA);
    assign m_axi_wvalid  = in_data & valid;
    assign ready         = in_data & m_axi_wready;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = wstrb;
    assign m_axi_wlast   = in_data && (beat_cnt == (len_r - 9'd1));
    assign m_axi_bready  = (state == W_BURST_RESP);
    assign state_dbg     = state;
    assign unused_bid    = ^m_axi_bid;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awsize  = AXI_SIZE_W'(LOG2_BYTES);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_VAL;
    assign m_axi_awprot  = AXI_PROT_VAL;
    assign m_axi_awqos   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= W_BURST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            len_r         <= '0;
            beat_cnt      <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_awlen   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                W_BURST_IDLE: begin
                    if (start) begin
                        addr      <= nxt_addr;
                        remaining <= nxt_rem;
                        error     <= 1'b0;
                        if (nxt_rem == '0) begin
                            done <= 1'b1;
                        end else begin
                            state         <= W_BURST_ADDR;
                            busy          <= 1'b1;
                            m_axi_awvalid <= 1'b1;
                            m_axi_awlen   <= AXI_LEN_W'(nxt_len - 9'd1);
                            len_r         <= nxt_len;
                        end
                    end
                end
                W_BURST_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= W_BURST_DATA;
                    end
                end
                W_BURST_DATA: begin
                    if (valid && m_axi_wready) begin
                        if (m_axi_wlast) begin
                            beat_cnt <= '0;
                            state    <= W_BURST_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                W_BURST_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != AXI_RESP_OKAY) error <= 1'b1;
                        addr      <= nxt_addr;
                        remaining <= nxt_rem;
                        if (nxt_rem == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= W_BURST_IDLE;
                        end else begin
                            state         <= W_BURST_ADDR;
                            m_axi_awvalid <= 1'b1;
                            m_axi_awlen   <= AXI_LEN_W'(nxt_len - 9'd1);
                            len_r         <= nxt_len;
                        end
                    end
                end
                default: state <= W_BURST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_w_burst.sv
// Scoreboard bench for axi_dma_w_burst: directed transfers, AXI slave model, negedge monitors.
module tb_axi_dma_w_burst;
    import axi_dma_w_burst_pkg::*;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int SW     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [CNT_W-1:0]  num_beats = '0;
    logic              busy, done, error;
    logic              valid = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] wdata = '0;
    logic [SW-1:0]     wstrb = '0;
    logic [AXI_ID_W-1:0]    awid;
    logic [ADDR_W-1:0]      awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awlock;
    logic [3:0]             awcache;
    logic [2:0]             awprot;
    logic [3:0]             awqos;
    logic                   awvalid;
    logic                   awready = 1'b0;
    logic [DATA_W-1:0]      m_wdata;
    logic [SW-1:0]          m_wstrb;
    logic                   wlast, wvalid;
    logic                   wready = 1'b0;
    logic [AXI_ID_W-1:0]    bid = '0;
    logic [1:0]             bresp = 2'b00;
    logic                   bvalid = 1'b0;
    logic                   bready;
    logic [1:0]             state_dbg;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int aw_stall = 0;
    int wr_mode = 0;

    logic [ADDR_W+7:0]       exp_aw_q[$];
    logic [DATA_W+SW:0]      exp_w_q[$];
    logic [1:0]              exp_done_q[$];
    logic [1:0]              resp_q[$];
    int                      blen_q[$];

    axi_dma_w_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_LEN(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .error(error), .valid(valid), .ready(ready),
        .wdata(wdata), .wstrb(wstrb),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [295:0] act, input logic [295:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI slave model: awready after aw_stall cycles, wready per wr_mode, one B per wlast.
    initial begin
        logic hs_last, hs_b;
        int   stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            hs_last = wvalid && wready && wlast;
            hs_b    = bvalid && bready;
            @(posedge clk);
            #1;
            if (rst) begin
                bvalid = 1'b0; awready = 1'b0; wready = 1'b0; stall_cnt = 0;
            end else begin
                if (hs_b) bvalid = 1'b0;
                if (hs_last) begin
                    bvalid = 1'b1;
                    bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                end
                if (awvalid) begin
                    if (stall_cnt < aw_stall) begin
                        awready = 1'b0;
                        stall_cnt++;
                    end else begin
                        awready = 1'b1;
                    end
                end else begin
                    awready   = 1'b0;
                    stall_cnt = 0;
                end
                wready = (wr_mode == 1) ? ~wready : 1'b1;
            end
        end
    end

    // Monitor: pops expected AW/W/done entries whenever the DUT presents them.
    initial begin
        logic [ADDR_W+7:0]  aw_held;
        logic               aw_held_v;
        logic               prev_b_hs;
        logic [DATA_W+SW:0] ew;
        logic [ADDR_W+7:0]  ea;
        logic [1:0]         ed;
        aw_held_v = 1'b0;
        prev_b_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_held_v = 1'b0;
                prev_b_hs = 1'b0;
            end else begin
                if (awvalid) begin
                    if (aw_held_v) chk("aw_stable", {awaddr, awlen}, aw_held);
                    if (awready) begin
                        aw_held_v = 1'b0;
                        if (exp_aw_q.size() == 0) chk("aw_unexpected", {awaddr, awlen}, '1);
                        else begin
                            ea = exp_aw_q.pop_front();
                            chk("aw_addr_len", {awaddr, awlen}, ea);
                            chk("aw_fixed", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
                                {4'd0, 3'd5, 2'b01, 1'b0, 4'd2, 3'b010, 4'd0});
                            chk("aw_busy", busy, 1'b1);
                        end
                    end else begin
                        aw_held   = {awaddr, awlen};
                        aw_held_v = 1'b1;
                    end
                end
                if (ready) chk("ready_in_data", state_dbg, W_BURST_DATA);
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) chk("w_unexpected", {wlast, m_wstrb, m_wdata}, '1);
                    else begin
                        ew = exp_w_q.pop_front();
                        chk("w_beat", {wlast, m_wstrb, m_wdata}, ew);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done_q.size() == 0) chk("done_unexpected", done, 1'b0);
                    else begin
                        ed = exp_done_q.pop_front();
                        chk("done_error", error, ed[0]);
                        if (!ed[1]) chk("done_after_b", prev_b_hs, 1'b1);
                    end
                end
                prev_b_hs = bvalid && bready;
            end
        end
    end

    task automatic plan_aw(input logic [ADDR_W-1:0] a, input int len);
        exp_aw_q.push_back({a, 8'(len - 1)});
        blen_q.push_back(len);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {ready, busy, done, error, awvalid, wvalid, wlast, bready, awaddr, awlen},
            '0);
    endtask

    task automatic xfer(input logic [ADDR_W-1:0] a, input int n, input int gap_max,
                        input logic err_exp, input int abort_at);
        logic [DATA_W-1:0] dq[$];
        logic [SW-1:0]     sq[$];
        logic [DATA_W-1:0] d;
        logic [SW-1:0]     s;
        logic              last, hs;
        int bi, pos, to, d0;
        bi = 0; pos = 0;
        for (int i = 0; i < n; i++) begin
            d = {8{32'(a) ^ 32'(i * 32'h0101_0101)}};
            s = SW'({$urandom, $urandom});
            pos++;
            last = (bi < blen_q.size()) && (pos == blen_q[bi]);
            if (last) begin bi++; pos = 0; end
            dq.push_back(d);
            sq.push_back(s);
            exp_w_q.push_back({last, s, d});
        end
        exp_done_q.push_back({n == 0, err_exp});
        blen_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        start_addr = a; num_beats = CNT_W'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("error_cleared", error, 1'b0);
        if (n == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_no_aw", awvalid, 1'b0);
        end else begin
            chk("busy_after_start", busy, 1'b1);
        end
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            valid = 1'b1; wdata = dq[i]; wstrb = sq[i];
            if (i == abort_at) begin
                rst = 1'b1;
                exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete(); resp_q.delete();
                @(posedge clk); #1;
                valid = 1'b0;
                @(negedge clk);
                chk_reset_vals("reset_mid_xfer");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            to = 0;
            hs = 1'b0;
            while (!hs && to < 200) begin
                @(negedge clk);
                hs = ready;
                @(posedge clk); #1;
                to++;
            end
            if (!hs) chk("beat_timeout", 1'b0, 1'b1);
        end
        valid = 1'b0;
        to = 0;
        while (done_cnt == d0 && to < 500) begin
            @(posedge clk);
            to++;
        end
        if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("aw_q_empty", exp_aw_q.size(), 0);
        chk("w_q_empty", exp_w_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset_values");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single burst
        plan_aw(32'h1000, 16);
        xfer(32'h1000, 16, 0, 1'b0, -1);

        // Multi-burst, stream gaps
        plan_aw(32'h000, 16); plan_aw(32'h200, 16); plan_aw(32'h400, 8);
        xfer(32'h0, 40, 1, 1'b0, -1);

        // 4 KB boundary
`ifdef AXI_DMA_W_4K_SPLIT_EN
        plan_aw(32'hF80, 4); plan_aw(32'h1000, 12);
`else
        plan_aw(32'hF80, 16);
`endif
        xfer(32'hF80, 16, 0, 1'b0, -1);

        // SLVERR on the middle burst
        plan_aw(32'h3000, 16); plan_aw(32'h3200, 16); plan_aw(32'h3400, 8);
        resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
        xfer(32'h3000, 40, 0, 1'b1, -1);

        // Zero length (also clears the sticky error)
        xfer(32'h5000, 0, 0, 1'b0, -1);

        // Backpressure with an unaligned start address
        aw_stall = 5; wr_mode = 1;
        plan_aw(32'h6000, 16); plan_aw(32'h6200, 8);
        xfer(32'h6007, 24, 3, 1'b0, -1);
        aw_stall = 0; wr_mode = 0;

        // Reset on beat 5, then a clean transfer
        plan_aw(32'h2000, 16);
        xfer(32'h2000, 16, 0, 1'b0, 4);
        plan_aw(32'h2000, 16);
        xfer(32'h2000, 16, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
